vregfile_control_arbiter: RTL and testbench
===========================================

// Module: vregfile_control_arbiter
// PURPOSE
//  Shares the vector control register file (vl, matmul masks, 32 x WIDTH) between
//  two requesters: scalar core (s_*) and vector pipeline (v_*).
//  Independent round-robin arbitration of the one read port and the one write port.
//  Returns read data with 1-cycle latency; handles same-cycle read/write to one register.
//  Sits between the requesters and the regfile a_*/c_* ports.
// PARAMETERS
//  WIDTH        32  data width of control registers
//  NUMREGS      32  number of control registers
//  LOG2NUMREGS  5   register index width
// PORTS
//  clk             in   1            clock
//  resetn          in   1            asynchronous active-low reset
//  s_req/v_req     in   1            request valid; hold request and fields stable until gnt
//  s_we/v_we       in   1            1 = write, 0 = read
//  s_reg/v_reg     in   LOG2NUMREGS  register index
//  s_wdata/v_wdata in   WIDTH        write data
//  s_gnt/v_gnt     out  1            combinational grant; request accepted this cycle
//  s_rvalid/v_rvalid out 1           registered; read data valid (cycle after read grant)
//  s_rdata/v_rdata out  WIDTH        read data, meaningful only while rvalid=1
//  rf_a_reg        out  LOG2NUMREGS  regfile read address
//  rf_a_en         out  1            regfile read enable
//  rf_a_readdata   in   WIDTH        regfile read data; address registered, valid next cycle
//  rf_c_reg        out  LOG2NUMREGS  regfile write address
//  rf_c_writedata  out  WIDTH        regfile write data
//  rf_c_we         out  1            regfile write enable
// BEHAVIOUR
//  - Reset (async, resetn=0): rvalid=0, bypass flag/data=0, pending-owner=0,
//    rd_last=wr_last=V, so S wins the first conflict on each port.
//    rf_a_en, rf_c_we and gnt are 0 because they depend only on the requests.
//  - Read and write arbitration are separate each cycle, so one read and one write can both be granted.
//  - Write port:
//    - One writer requesting: that writer is granted.
//    - Both requesting: the requester != wr_last is granted.
//    - wr_last updates to the granted id on every write grant.
//    - On grant: rf_c_we=1; rf_c_reg/rf_c_writedata come from the winner.
//  - Read port: same round-robin rule, using rd_last.
//    - On grant: rf_a_en=1 and rf_a_reg=winner reg.
//    - Owner is registered; that owner's rvalid=1 in the next cycle.
//  - Idle outputs: rf_a_reg=0 and rf_c_reg=0 when not granted; writedata=0.
//  - Latency: grant in cycle t -> write committed at the t edge; read data/rvalid in t+1.
//  - Back-to-back: a requester may issue a new request in the cycle after its grant.
//  - RAW hazard: same cycle, read granted to one requester, write granted to the other,
//    same register. The RAM returns OLD_DATA in this case; handling depends on VCTRL_BYPASS_EN.
//  - A read following a write by >=1 cycle needs no special handling.
//  - A single requester never reads and writes in the same cycle (we selects one).
//  - Reset mid-operation: a pending read is dropped (no rvalid); in-flight write
//    outcome undefined only if reset coincides with its grant edge.
// CONFIGURATION
//  VCTRL_BYPASS_EN defined:
//    - Hazard read is granted.
//    - Write data is captured into a bypass register, with bypass flag=1.
//    - Next cycle, rdata = bypass data instead of rf_a_readdata.
//  VCTRL_BYPASS_EN undefined:
//    - Hazard read grant is withheld (gnt=0) and rd_last is not updated.
//    - The read is granted next cycle and returns the new value from the RAM, one cycle later.
//    - The write is unaffected.
// TESTING
//  1. S write reg5=0x1234 alone -> s_gnt=1, rf_c_we=1, rf_c_reg=5 same cycle.
//     S read reg5 next cycle -> s_rvalid=1, s_rdata=0x1234 one cycle after grant.
//  2. S and V read regs 1/2 every cycle for 4 cycles after reset
//     -> grants S,V,S,V; rvalid alternates accordingly with correct data.
//  3. S and V write reg3 (0xA, 0xB) simultaneously -> S first, V next cycle; final reg3=0xB.
//     Repeat with V as last -> S wins.
//  4. S writes reg0=16 while V reads reg0 (old value 8).
//     BYPASS_EN: both granted; v_rdata=16 next cycle.
//     Not defined: v_gnt=0 at t, v_gnt=1 at t+1, v_rdata=16 at t+2.
//  5. S reads reg30 while V writes reg31 -> both granted same cycle; s_rdata=old reg30.
//  6. Assert resetn=0 the cycle after V read grant
//     -> v_rvalid stays 0; after release first S/V conflict goes to S.

Source files
------------

// File: rtl/vregfile_control_arbiter.sv
// vregfile_control_arbiter: round-robin sharing of the control regfile read/write ports between scalar (S) and vector (V) requesters.
// Build option VCTRL_BYPASS_EN: forward same-cycle write data to a colliding read instead of stalling the read.
module vregfile_control_arbiter #(
  parameter int WIDTH = 32,
  parameter int NUMREGS = 32,
  parameter int LOG2NUMREGS = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_req,
  input  logic                   s_we,
  input  logic [LOG2NUMREGS-1:0] s_reg,
  input  logic [WIDTH-1:0]       s_wdata,
  output logic                   s_gnt,
  output logic                   s_rvalid,
  output logic [WIDTH-1:0]       s_rdata,
  input  logic                   v_req,
  input  logic                   v_we,
  input  logic [LOG2NUMREGS-1:0] v_reg,
  input  logic [WIDTH-1:0]       v_wdata,
  output logic                   v_gnt,
  output logic                   v_rvalid,
  output logic [WIDTH-1:0]       v_rdata,
  output logic [LOG2NUMREGS-1:0] rf_a_reg,
  output logic                   rf_a_en,
  input  logic [WIDTH-1:0]       rf_a_readdata,
  output logic [LOG2NUMREGS-1:0] rf_c_reg,
  output logic [WIDTH-1:0]       rf_c_writedata,
  output logic                   rf_c_we
);
  if (NUMREGS > (1 << LOG2NUMREGS)) begin : g_bad_cfg
    $error("NUMREGS does not fit in LOG2NUMREGS bits");
  end
  logic s_wr, v_wr, s_rd, v_rd;
  logic wr_s, wr_v, rd_sc, rd_vc, rd_s, rd_v, hazard;
  logic wr_last, rd_last;
  logic [LOG2NUMREGS-1:0] rd_reg, wr_reg;
  assign s_wr = s_req & s_we;
  assign v_wr = v_req & v_we;
  assign s_rd = s_req & ~s_we;
  assign v_rd = v_req & ~v_we;
  // last-winner flags: 1 = V, so V only wins a conflict right after S did
  assign wr_v = v_wr & (~s_wr | ~wr_last);
  assign wr_s = s_wr & ~wr_v;
  assign rd_vc = v_rd & (~s_rd | ~rd_last);
  assign rd_sc = s_rd & ~rd_vc;
  assign rd_reg = rd_sc ? s_reg : v_reg;
  assign wr_reg = wr_s ? s_reg : v_reg;
  assign hazard = (rd_sc | rd_vc) & (wr_s | wr_v) & (rd_reg == wr_reg);
`ifdef VCTRL_BYPASS_EN
  logic byp;
  logic [WIDTH-1:0] byp_data;
  assign rd_s = rd_sc;
  assign rd_v = rd_vc;
  assign s_rdata = byp ? byp_data : rf_a_readdata;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      byp <= 1'b0;
      byp_data <= '0;
    end else begin
      byp <= hazard;
      byp_data <= rf_c_writedata;
    end
`else
  assign rd_s = rd_sc & ~hazard;
  assign rd_v = rd_vc & ~hazard;
  assign s_rdata = rf_a_readdata;
`endif
  assign v_rdata = s_rdata;
  assign s_gnt = wr_s | rd_s;
  assign v_gnt = wr_v | rd_v;
  assign rf_c_we = wr_s | wr_v;
  assign rf_c_reg = rf_c_we ? wr_reg : '0;
  assign rf_c_writedata = wr_s ? s_wdata : wr_v ? v_wdata : '0;
  assign rf_a_en = rd_s | rd_v;
  assign rf_a_reg = rf_a_en ? rd_reg : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      s_rvalid <= 1'b0;
      v_rvalid <= 1'b0;
      wr_last <= 1'b1;
      rd_last <= 1'b1;
    end else begin
      s_rvalid <= rd_s;
      v_rvalid <= rd_v;
      if (rf_c_we) wr_last <= wr_v;
      if (rf_a_en) rd_last <= rd_v;
    end
endmodule

// File: tb/tb_vregfile_control_arbiter.sv
// tb_vregfile_control_arbiter: directed and random checks of the control regfile arbiter against a behavioural model.
module tb_vregfile_control_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic s_req, s_we, v_req, v_we;
  logic [4:0] s_reg, v_reg;
  logic [31:0] s_wdata, v_wdata;
  logic s_gnt, v_gnt, s_rvalid, v_rvalid;
  logic [31:0] s_rdata, v_rdata;
  logic [4:0] rf_a_reg, rf_c_reg;
  logic rf_a_en, rf_c_we;
  logic [31:0] rf_a_readdata, rf_c_writedata;

  always #5 clk = ~clk;

  vregfile_control_arbiter dut (
    .clk(clk), .resetn(resetn),
    .s_req(s_req), .s_we(s_we), .s_reg(s_reg), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_reg(v_reg), .v_wdata(v_wdata),
    .v_gnt(v_gnt), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
    .rf_a_reg(rf_a_reg), .rf_a_en(rf_a_en), .rf_a_readdata(rf_a_readdata),
    .rf_c_reg(rf_c_reg), .rf_c_writedata(rf_c_writedata), .rf_c_we(rf_c_we)
  );

  // regfile RAM: registered read address, returns old data on a same-edge write
  logic [31:0] mem [32];
  logic ram_init;
  always @(posedge clk)
    if (ram_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(8 * (i + 1));
    end else begin
      if (rf_c_we) mem[rf_c_reg] <= rf_c_writedata;
      if (rf_a_en) rf_a_readdata <= mem[rf_a_reg];
    end

  int errors = 0;
  int checks = 0;

  // behavioural model state: committed register values, last winners (0=S, 1=V), expected read return
  logic [31:0] shadow [32];
  int wlast, rlast;
  logic exp_rv_s, exp_rv_v;
  logic [31:0] exp_rd;
  logic gs_m, gv_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wlast = 1;
    rlast = 1;
    exp_rv_s = 1'b0;
    exp_rv_v = 1'b0;
  endtask

  task automatic step(input logic sr, sw, input logic [4:0] sg, input logic [31:0] sd,
                      input logic vr, vw, input logic [4:0] vg, input logic [31:0] vd);
    int ww, rw;
    logic [4:0] wreg, rreg;
    @(negedge clk);
    chk("s_rvalid", s_rvalid, exp_rv_s);
    chk("v_rvalid", v_rvalid, exp_rv_v);
    if (exp_rv_s) chk("s_rdata", s_rdata, exp_rd);
    if (exp_rv_v) chk("v_rdata", v_rdata, exp_rd);
    s_req = sr; s_we = sw; s_reg = sg; s_wdata = sd;
    v_req = vr; v_we = vw; v_reg = vg; v_wdata = vd;
    #1;
    ww = (sr && sw && vr && vw) ? 1 - wlast : (sr && sw) ? 0 : (vr && vw) ? 1 : -1;
    rw = (sr && !sw && vr && !vw) ? 1 - rlast : (sr && !sw) ? 0 : (vr && !vw) ? 1 : -1;
    wreg = (ww == 0) ? sg : vg;
    rreg = (rw == 0) ? sg : vg;
`ifndef VCTRL_BYPASS_EN
    if (rw >= 0 && ww >= 0 && rreg == wreg) rw = -1;
`endif
    gs_m = (ww == 0) || (rw == 0);
    gv_m = (ww == 1) || (rw == 1);
    chk("s_gnt", s_gnt, gs_m);
    chk("v_gnt", v_gnt, gv_m);
    chk("rf_c_we", rf_c_we, ww >= 0);
    chk("rf_c_reg", rf_c_reg, ww >= 0 ? wreg : 5'd0);
    chk("rf_c_writedata", rf_c_writedata, ww == 0 ? sd : ww == 1 ? vd : 32'd0);
    chk("rf_a_en", rf_a_en, rw >= 0);
    chk("rf_a_reg", rf_a_reg, rw >= 0 ? rreg : 5'd0);
    // a read observes every write granted in the same cycle or earlier
    if (ww >= 0) begin
      shadow[wreg] = ww == 0 ? sd : vd;
      wlast = ww;
    end
    if (rw >= 0) rlast = rw;
    exp_rv_s = rw == 0;
    exp_rv_v = rw == 1;
    exp_rd = shadow[rreg];
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [3:0] seq;
  logic sr, sw, vr, vw;
  logic [4:0] sg, vg;
  logic [31:0] sd, vd;

  initial begin
    resetn = 1'b0;
    ram_init = 1'b1;
    {s_req, s_we, s_reg, s_wdata, v_req, v_we, v_reg, v_wdata} = '0;
    for (int i = 0; i < 32; i++) shadow[i] = 32'(8 * (i + 1));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_v_rvalid", v_rvalid, 0);
    chk("rst_gnt", {s_gnt, v_gnt, rf_a_en, rf_c_we}, 0);
    resetn = 1'b1;

    // both read every cycle: S first, then alternate
    seq = '0;
    sr = 1; vr = 1;
    for (int i = 0; i < 4; i++) begin
      step(sr, 0, 1, 0, vr, 0, 2, 0);
      seq[i] = s_gnt;
    end
    chk("rr_order", seq, 4'b0101);

    step(1, 1, 5, 32'h1234, 0, 0, 0, 0);
    chk("w5_gnt", s_gnt, 1);
    chk("w5_reg", rf_c_reg, 5);
    step(1, 0, 5, 0, 0, 0, 0, 0);
    idle();
    chk("r5_data", s_rdata, 32'h1234);
    chk("r5_valid", s_rvalid, 1);

    step(0, 0, 0, 0, 1, 1, 10, 32'h55);
    step(1, 1, 3, 32'hA, 1, 1, 3, 32'hB);
    chk("w3_s_first", {s_gnt, v_gnt}, 2'b10);
    step(0, 0, 0, 0, 1, 1, 3, 32'hB);
    chk("w3_v_next", v_gnt, 1);
    step(1, 0, 3, 0, 0, 0, 0, 0);
    idle();
    chk("r3_final", s_rdata, 32'hB);

    step(1, 1, 0, 32'd16, 1, 0, 0, 0);
    chk("raw_s_gnt", s_gnt, 1);
`ifdef VCTRL_BYPASS_EN
    chk("raw_v_gnt", v_gnt, 1);
`else
    chk("raw_v_gnt", v_gnt, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("raw_v_gnt_late", v_gnt, 1);
`endif
    idle();
    chk("raw_v_rdata", v_rdata, 32'd16);

    step(1, 0, 30, 0, 1, 1, 31, 32'h77);
    chk("rw_diff_gnt", {s_gnt, v_gnt}, 2'b11);
    idle();
    chk("rw_diff_old", s_rdata, 32'd248);

    step(0, 0, 0, 0, 1, 0, 7, 0);
    chk("rst_v_gnt", v_gnt, 1);
    resetn = 1'b0;
    model_reset();
    idle();
    chk("rst_drop", v_rvalid, 0);
    resetn = 1'b1;
    step(1, 0, 4, 0, 1, 0, 5, 0);
    chk("rst_s_wins", {s_gnt, v_gnt}, 2'b10);
    idle();

    sr = 0; vr = 0; sw = 0; vw = 0; sg = 0; vg = 0; sd = 0; vd = 0;
    gs_m = 0; gv_m = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!sr || gs_m) begin
        sr = ($urandom % 4) != 0;
        sw = $urandom % 2;
        sg = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        sd = $urandom;
      end
      if (!vr || gv_m) begin
        vr = ($urandom % 4) != 0;
        vw = $urandom % 2;
        vg = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        vd = $urandom;
      end
      step(sr, sw, sg, sd, vr, vw, vg, vd);
    end
    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
